s_mem_arbiter: RTL and testbench
================================

Name: s_mem_arbiter

Overview:
Arbitrates single-port access to the RC4 S-box working memory (256x8) between the pipeline's sequencing FSMs: init, shuffle/KSA and decrypt/PRGA, plus spares. Round-robin grant with ownership lock: a requester keeps the memory until it pulses done. A hold-time watchdog forces release from a hung owner. Sits between the phase FSMs and the S-memory instance; read data is broadcast and is valid only to the owner.

Parameters:
N_REQ, 3, number of requesters (2..8)
ADDR_WIDTH, 8, S-memory address width
DATA_WIDTH, 8, S-memory data width
MAX_HOLD, 1024, max owned cycles before forced release; 0 disables watchdog

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
req  in  N_REQ  per-requester access request, level
done  in  N_REQ  per-requester release pulse, only owner's bit honoured
req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses, slice i = requester i
req_wrdata  in  N_REQ*DATA_WIDTH  flattened write data
req_wren  in  N_REQ  per-requester write enable
gnt  out  N_REQ  one-hot grant, all-zero when idle
mem_addr  out  ADDR_WIDTH  to S-memory
mem_wrdata  out  DATA_WIDTH  to S-memory
mem_wren  out  1  to S-memory
busy  out  1  high while any grant is held
timeout_err  out  1  sticky, watchdog fired
timeout_id  out  $clog2(N_REQ)  index of last owner released by watchdog

Behaviour:
- Reset: gnt=0, busy=0, timeout_err=0, timeout_id=0, rr pointer=0, hold counter=0, state IDLE. Reset overrides all simultaneous events.
- States: IDLE, OWNED.
- IDLE: if any req bit is high, pick the first set bit searching from the rr pointer upward with wrap (pointer, pointer+1, ..., N_REQ-1, 0, ...). Register owner=i, gnt[i]=1, busy=1, and go to OWNED on the next edge. Grant latency is 1 cycle from req sampled high. No req keeps IDLE.
- OWNED: mem_addr, mem_wrdata and mem_wren are combinationally muxed from the owner's slices. In IDLE they are mem_addr=0, mem_wrdata=0, mem_wren=0, so there are never stray writes.
- Release: done[owner]=1 in any OWNED cycle, including the first, gives IDLE on the next edge, gnt=0, busy=0, and rr pointer=(owner+1) mod N_REQ. There is always at least one IDLE cycle between owners. Arbitration happens in that cycle, so back-to-back owners are separated by exactly 1 gap cycle.
- done from a non-owner is ignored. Dropping req while owned does not release; only done or the watchdog releases.
- Watchdog (MAX_HOLD>0): hold counter clears on grant and increments each OWNED cycle. If the counter equals MAX_HOLD-1 and done[owner]=0, then release as above, timeout_err<=1 (sticky until reset), and timeout_id<=owner. If done arrives on that same cycle, done wins and no error is raised. The counter width is $clog2(MAX_HOLD+1).
- Read data path: not routed through the arbiter; the owner samples S-memory q directly with the memory's own latency.
- Reset mid-ownership: grant is dropped on the same edge and the pointer returns to 0.

Decomposition:
- Shared package rc4_pkg: arb_state_t enum {ARB_IDLE, ARB_OWNED}, localparam S_MEM_DEPTH=256.
- One sub-module, rr_pick: a combinational round-robin picker with inputs req and pointer, and outputs valid and index. The FSM, owner register, counter and output mux live in s_mem_arbiter.

Test Plan:
- After reset, req=3'b010 → at cycle+1 gnt=3'b010 and busy=1. Owner's addr=8'h2A, wren=1 → mem_addr=8'h2A, mem_wren=1. Pulse done[1] → next cycle gnt=0 and mem_wren=0.
- req=3'b111 held, each owner pulses done after 4 cycles → grant order 0,1,2,0 with exactly 1 idle cycle between grants.
- Owner 0 holds while req[2] rises and done[2] pulses → gnt stays 3'b001. Owner drops req without done → grant retained.
- MAX_HOLD=16, owner 1 never pulses done → gnt drops after 16 OWNED cycles, timeout_err=1, timeout_id=1. Next grant goes to 2 if requesting.
- MAX_HOLD=16, done[owner] on the 16th owned cycle → clean release, timeout_err stays 0.
- Reset asserted mid-ownership together with done → gnt=0, busy=0, timeout_err=0. With req=3'b101 afterwards → first grant is 0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 pipeline S-memory slice.
package rc4_pkg;

  // Depth of the S-box working memory (one entry per byte value).
  localparam int S_MEM_DEPTH = 256;

  // Arbiter ownership state.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // (base + step) mod n, assuming base < n and step < n.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    int unsigned sum;
    sum = base + step;
    if (sum >= n) begin
      sum = sum - n;
    end else begin
      sum = sum;
    end
    return sum;
  endfunction

endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping from N_REQ-1 back to 0.
module rr_pick
  import rc4_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    valid  = 1'b0;
    index  = {IDX_W{1'b0}};
    cand_s = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = IDX_W'(rr_wrap(int'(pointer), k, N_REQ));
      hit_s  = req[cand_s] & ~valid;
      index  = hit_s ? cand_s : index;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// Single-port S-box memory arbiter: round-robin grant with ownership lock,
// release on the owner's done pulse or on the hold-time watchdog.
module s_mem_arbiter
  import rc4_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              done,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wrdata,
  input  logic [N_REQ-1:0]              req_wren,
  output logic [N_REQ-1:0]              gnt,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wrdata,
  output logic                          mem_wren,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [$clog2(N_REQ)-1:0]      timeout_id
);

  localparam int IDW   = $clog2(N_REQ);
  localparam bit WD_EN = (MAX_HOLD > 0);
  // A zero MAX_HOLD would give a zero-width counter; keep one bit instead.
  localparam int CW    = WD_EN ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0]    HOLD_LAST = WD_EN ? CW'(MAX_HOLD - 1) : CW'(0);
  localparam logic [N_REQ-1:0] GNT_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_t       state_r;
  logic [IDW-1:0]   owner_r;
  logic [IDW-1:0]   ptr_r;
  logic [CW-1:0]    hold_r;
  logic [N_REQ-1:0] gnt_r;
  logic             busy_r;
  logic             timeout_err_r;
  logic [IDW-1:0]   timeout_id_r;

  logic             pick_valid_s;
  logic [IDW-1:0]   pick_idx_s;
  logic             owner_done_s;
  logic             wd_fire_s;
  logic [IDW-1:0]   next_ptr_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDW)
  ) u_rr_pick (
    .req     (req),
    .pointer (ptr_r),
    .valid   (pick_valid_s),
    .index   (pick_idx_s)
  );

  // Only the owner's done bit is honoured; non-owner pulses are ignored.
  assign owner_done_s = done[owner_r];
  // Watchdog fires on the last permitted owned cycle; done takes priority.
  assign wd_fire_s    = WD_EN && (hold_r == HOLD_LAST);
  // Pointer moves just past the releasing owner for fairness.
  assign next_ptr_s   = IDW'(rr_wrap(int'(owner_r), 1, N_REQ));

  // Ownership FSM, round-robin pointer, hold counter and watchdog flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ARB_IDLE;
      owner_r       <= {IDW{1'b0}};
      ptr_r         <= {IDW{1'b0}};
      hold_r        <= {CW{1'b0}};
      gnt_r         <= {N_REQ{1'b0}};
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      timeout_id_r  <= {IDW{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_valid_s) begin
            state_r <= ARB_OWNED;
            owner_r <= pick_idx_s;
            gnt_r   <= GNT_ONE << pick_idx_s;
            busy_r  <= 1'b1;
            hold_r  <= {CW{1'b0}};
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_OWNED: begin
          if (owner_done_s) begin
            state_r <= ARB_IDLE;
            gnt_r   <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= next_ptr_s;
          end else if (wd_fire_s) begin
            state_r       <= ARB_IDLE;
            gnt_r         <= {N_REQ{1'b0}};
            busy_r        <= 1'b0;
            ptr_r         <= next_ptr_s;
            timeout_err_r <= 1'b1;
            timeout_id_r  <= owner_r;
          end else begin
            hold_r <= hold_r + CW'(1);
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          gnt_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Route the owner's request slices to the memory; drive zeros when idle
  // so the memory never sees a stray write.
  always_comb begin
    mem_addr   = {ADDR_WIDTH{1'b0}};
    mem_wrdata = {DATA_WIDTH{1'b0}};
    mem_wren   = 1'b0;
    case (state_r)
      ARB_OWNED: begin
        mem_addr   = req_addr[int'(owner_r)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wrdata = req_wrdata[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
        mem_wren   = req_wren[owner_r];
      end
      ARB_IDLE: begin
        mem_addr   = {ADDR_WIDTH{1'b0}};
        mem_wrdata = {DATA_WIDTH{1'b0}};
        mem_wren   = 1'b0;
      end
      default: begin
        mem_addr   = {ADDR_WIDTH{1'b0}};
        mem_wrdata = {DATA_WIDTH{1'b0}};
        mem_wren   = 1'b0;
      end
    endcase
  end

  assign gnt         = gnt_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign timeout_id  = timeout_id_r;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed self-checking bench for s_mem_arbiter (N_REQ=3, MAX_HOLD=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_s_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MH = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wrdata;
  logic [N-1:0]    req_wren;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wrdata;
  logic            mem_wren;
  logic            busy;
  logic            timeout_err;
  logic [1:0]      timeout_id;

  int n_checks;
  int n_fail;

  s_mem_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_HOLD   (MH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .req_addr    (req_addr),
    .req_wrdata  (req_wrdata),
    .req_wren    (req_wren),
    .gnt         (gnt),
    .mem_addr    (mem_addr),
    .mem_wrdata  (mem_wrdata),
    .mem_wren    (mem_wren),
    .busy        (busy),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 3'b000;
    done  = 3'b000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int     cnt;
  logic   err_before;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req        = 3'b000;
    done       = 3'b000;
    req_addr   = 24'h000000;
    req_wrdata = 24'h000000;
    req_wren   = 3'b000;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(timeout_err), 32'd0);
    check("rst_id",    32'(timeout_id), 32'd0);
    check("rst_wren",  32'(mem_wren), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);

    // Single grant to requester 1 and mux check
    reset = 1'b0;
    req   = 3'b010;
    req_addr[0 +: 8]    = 8'h11;
    req_wren[0]         = 1'b1;
    req_addr[8 +: 8]    = 8'h2A;
    req_wrdata[8 +: 8]  = 8'h5C;
    req_wren[1]         = 1'b1;
    req_addr[16 +: 8]   = 8'h77;
    #1;
    check("idle_wren", 32'(mem_wren), 32'd0);
    check("idle_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("t1_gnt",    32'(gnt), 32'b010);
    check("t1_busy",   32'(busy), 32'd1);
    check("t1_addr",   32'(mem_addr), 32'h2A);
    check("t1_wdata",  32'(mem_wrdata), 32'h5C);
    check("t1_wren",   32'(mem_wren), 32'd1);
    done = 3'b010;
    @(negedge clk);
    check("t1_rel_gnt",  32'(gnt), 32'd0);
    check("t1_rel_busy", 32'(busy), 32'd0);
    check("t1_rel_wren", 32'(mem_wren), 32'd0);
    done = 3'b000;
    req  = 3'b000;

    // Round-robin order 0,1,2,0 with one idle cycle between owners
    do_reset();
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(3'b001 << (g % 3)));
      repeat (3) @(negedge clk);
      check($sformatf("rr_hold%0d", g), 32'(gnt), 32'(3'b001 << (g % 3)));
      done = 3'b001 << (g % 3);
      @(negedge clk);
      check($sformatf("rr_gap%0d", g), 32'(gnt), 32'd0);
      done = 3'b000;
    end
    req = 3'b000;

    // Non-owner done ignored; dropping req does not release
    do_reset();
    req = 3'b001;
    @(negedge clk);
    check("lk_gnt", 32'(gnt), 32'b001);
    req  = 3'b101;
    done = 3'b100;
    @(negedge clk);
    done = 3'b000;
    check("lk_nodone", 32'(gnt), 32'b001);
    req = 3'b000;
    repeat (2) @(negedge clk);
    check("lk_drop_gnt",  32'(gnt), 32'b001);
    check("lk_drop_busy", 32'(busy), 32'd1);
    done = 3'b001;
    @(negedge clk);
    check("lk_rel", 32'(gnt), 32'd0);
    done = 3'b000;

    // Watchdog: owner 1 hangs, released after 16 owned cycles
    do_reset();
    req = 3'b110;
    cnt = 0;
    err_before = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt == 3'b010) begin
        cnt++;
        err_before = err_before | timeout_err;
      end else begin
        break;
      end
    end
    check("wd_cycles",  32'(cnt), 32'd16);
    check("wd_pre_err", 32'(err_before), 32'd0);
    check("wd_gnt",     32'(gnt), 32'd0);
    check("wd_err",     32'(timeout_err), 32'd1);
    check("wd_id",      32'(timeout_id), 32'd1);
    @(negedge clk);
    check("wd_next",    32'(gnt), 32'b100);
    check("wd_sticky",  32'(timeout_err), 32'd1);

    // Reset mid-ownership together with done
    reset = 1'b1;
    done  = 3'b100;
    @(negedge clk);
    check("mr_gnt",  32'(gnt), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err",  32'(timeout_err), 32'd0);
    check("mr_id",   32'(timeout_id), 32'd0);
    reset = 1'b0;
    done  = 3'b000;
    req   = 3'b101;
    @(negedge clk);
    check("mr_first", 32'(gnt), 32'b001);
    done = 3'b001;
    @(negedge clk);
    done = 3'b000;
    req  = 3'b000;

    // done on the 16th owned cycle wins over the watchdog
    do_reset();
    req = 3'b001;
    @(negedge clk);
    check("dw_gnt", 32'(gnt), 32'b001);
    repeat (15) @(negedge clk);
    check("dw_hold16", 32'(gnt), 32'b001);
    done = 3'b001;
    @(negedge clk);
    done = 3'b000;
    req  = 3'b000;
    check("dw_rel", 32'(gnt), 32'd0);
    check("dw_err", 32'(timeout_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
